// File: rtl/rip_axi_master_if.sv
`default_nettype none
//==============================================================================
// Module   : rip_axi_interface
// Desc     : AXI4 channel bundle (AW/W/B/AR/R) with master and slave views.
// Revision : 1.0 - initial release
//==============================================================================
interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/rip_axi_master.sv
`default_nettype none
//==============================================================================
// Module   : rip_axi_master
// Desc     : Single-request user port to AXI4 master bridge. Each request is
//            one fixed-length INCR burst; write and read paths run independently.
// Revision : 1.0 - initial release
//==============================================================================
module rip_axi_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 2
) (
    input  wire logic                              clk,
    input  wire logic                              rstn,
    // user write port
    output logic                                   wready,
    input  wire logic [ADDR_WIDTH-1:0]             waddr,
    input  wire logic [DATA_WIDTH*BURST_LEN-1:0]   wdata,
    input  wire logic [DATA_WIDTH*BURST_LEN/8-1:0] wstrb,
    input  wire logic                              wvalid,
    output logic                                   wdone,
    // user read port
    output logic                                   rready,
    input  wire logic [ADDR_WIDTH-1:0]             raddr,
    input  wire logic                              rvalid,
    output logic [DATA_WIDTH*BURST_LEN-1:0]        rdata,
    output logic                                   rdone,
    // AXI4 master
    rip_axi_interface.master                       M_AXI
);
    localparam int B_WIDTH = 8;
    localparam int STRB_W  = DATA_WIDTH / B_WIDTH;
    localparam int CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [7:0]       C_AXLEN     = 8'(BURST_LEN - 1);
    localparam logic [2:0]       C_AXSIZE    = 3'($clog2(STRB_W));
    localparam logic [1:0]       C_INCR      = 2'b01;
    localparam logic [3:0]       C_CACHE     = 4'b0011;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    // ------------------------------------------------------------------ write
    wstate_t                              wstate_q, wstate_d;
    logic [CNT_W-1:0]                     wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]                waddr_q;
    logic [BURST_LEN-1:0][DATA_WIDTH-1:0] wdata_q;
    logic [BURST_LEN-1:0][STRB_W-1:0]     wstrb_q;
    logic                                 wready_q;
    logic                                 wdone_q;
    logic                                 w_waccept;

    assign w_waccept = wvalid && wready_q;

    // Write FSM next-state and beat counter
    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        case (wstate_q)
            W_IDLE: if (w_waccept) wstate_d = W_ADDR;
            W_ADDR: if (M_AXI.awready) wstate_d = W_DATA;
            W_DATA: begin
                if (M_AXI.wready) begin
                    if (wcnt_q == C_LAST_BEAT) begin
                        wcnt_d   = '0;
                        wstate_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            W_RESP: if (M_AXI.bvalid) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write state, handshake flags and captured request payload
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
            wready_q <= 1'b0;
            wdone_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            // ready only re-asserts once the FSM has sat in idle for a cycle,
            // so it stays low through the done pulse
            wready_q <= (wstate_d == W_IDLE) && (wstate_q == W_IDLE);
            wdone_q  <= (wstate_q == W_RESP) && M_AXI.bvalid;
            if (w_waccept) begin
                waddr_q <= waddr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    assign wready = wready_q;
    assign wdone  = wdone_q;

    assign M_AXI.awid     = '0;
    assign M_AXI.awaddr   = waddr_q;
    assign M_AXI.awlen    = C_AXLEN;
    assign M_AXI.awsize   = C_AXSIZE;
    assign M_AXI.awburst  = C_INCR;
    assign M_AXI.awlock   = 1'b0;
    assign M_AXI.awcache  = C_CACHE;
    assign M_AXI.awprot   = '0;
    assign M_AXI.awqos    = '0;
    assign M_AXI.awregion = '0;
    assign M_AXI.awvalid  = (wstate_q == W_ADDR);
    assign M_AXI.wdata    = wdata_q[wcnt_q];
    assign M_AXI.wstrb    = wstrb_q[wcnt_q];
    assign M_AXI.wlast    = (wstate_q == W_DATA) && (wcnt_q == C_LAST_BEAT);
    assign M_AXI.wvalid   = (wstate_q == W_DATA);
    assign M_AXI.bready   = (wstate_q == W_RESP);

    // ------------------------------------------------------------------- read
    rstate_t                              rstate_q, rstate_d;
    logic [CNT_W-1:0]                     rcnt_q, rcnt_d;
    logic [ADDR_WIDTH-1:0]                raddr_q;
    logic [BURST_LEN-1:0][DATA_WIDTH-1:0] rdata_q;
    logic                                 rready_q;
    logic                                 rdone_q;
    logic                                 w_raccept;
    logic                                 w_rbeat;

    assign w_raccept = rvalid && rready_q;
    assign w_rbeat   = (rstate_q == R_DATA) && M_AXI.rvalid;

    // Read FSM next-state and beat counter; RLAST ends the burst
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        case (rstate_q)
            R_IDLE: if (w_raccept) rstate_d = R_ADDR;
            R_ADDR: if (M_AXI.arready) rstate_d = R_DATA;
            R_DATA: begin
                if (M_AXI.rvalid) begin
                    if (M_AXI.rlast) begin
                        rcnt_d   = '0;
                        rstate_d = R_IDLE;
                    end else if (rcnt_q != C_LAST_BEAT) begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read state, handshake flags and beat capture into the payload register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            rready_q <= 1'b0;
            rdone_q  <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rready_q <= (rstate_d == R_IDLE) && (rstate_q == R_IDLE);
            rdone_q  <= w_rbeat && M_AXI.rlast;
            if (w_raccept) begin
                raddr_q <= raddr;
            end
            if (w_rbeat) begin
                rdata_q[rcnt_q] <= M_AXI.rdata;
            end
        end
    end

    assign rready = rready_q;
    assign rdone  = rdone_q;
    assign rdata  = rdata_q;

    assign M_AXI.arid     = '0;
    assign M_AXI.araddr   = raddr_q;
    assign M_AXI.arlen    = C_AXLEN;
    assign M_AXI.arsize   = C_AXSIZE;
    assign M_AXI.arburst  = C_INCR;
    assign M_AXI.arlock   = 1'b0;
    assign M_AXI.arcache  = C_CACHE;
    assign M_AXI.arprot   = '0;
    assign M_AXI.arqos    = '0;
    assign M_AXI.arregion = '0;
    assign M_AXI.arvalid  = (rstate_q == R_ADDR);
    assign M_AXI.rready   = (rstate_q == R_DATA);

    // Response IDs and status codes carry no meaning for this bridge
    logic w_unused_ok;
    assign w_unused_ok = ^{M_AXI.bid, M_AXI.bresp, M_AXI.rid, M_AXI.rresp};

endmodule
`default_nettype wire

// File: tb/tb_rip_axi_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_rip_axi_master
// Desc     : Scoreboard bench for rip_axi_master with a byte-memory AXI slave.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rip_axi_master;
    localparam int ID_W = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BL   = 2;
    localparam int PW   = DW * BL;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          wready, wdone, rready_u, rdone;
    logic          wvalid   = 1'b0;
    logic          rvalid_u = 1'b0;
    logic [AW-1:0] waddr    = '0;
    logic [AW-1:0] raddr    = '0;
    logic [PW-1:0] wdata    = '0;
    logic [PW/8-1:0] wstrb  = '0;
    logic [PW-1:0] rdata;

    rip_axi_interface #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    rip_axi_master #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .wready (wready),
        .waddr  (waddr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wdone  (wdone),
        .rready (rready_u),
        .raddr  (raddr),
        .rvalid (rvalid_u),
        .rdata  (rdata),
        .rdone  (rdone),
        .M_AXI  (axi)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------- slave model
    logic       stall  = 1'b0;
    logic       hold_w = 1'b0;
    logic       go_aw, go_w, go_r;
    logic       s_init = 1'b0;
    logic       s_awgot, s_bpend;
    logic [7:0] s_waddr;
    logic [8:0] s_wbeat;
    logic       s_rbusy, s_rvalid, s_rlast;
    logic [7:0] s_raddr, s_rlen;
    logic [8:0] s_rbeat;
    logic [31:0] s_rdata;
    logic [7:0] mem [0:255];

    logic       ar_hs, r_hs, r_busy_now;
    logic [8:0] r_nbeat;
    logic [7:0] r_len, r_addr, r_baddr, w_baddr;

    assign axi.awready = !s_awgot && !s_bpend && go_aw;
    assign axi.wready  = s_awgot && go_w;
    assign axi.bvalid  = s_bpend;
    assign axi.bid     = '0;
    assign axi.bresp   = 2'b10;
    assign axi.arready = !s_rbusy;
    assign axi.rvalid  = s_rvalid;
    assign axi.rdata   = s_rdata;
    assign axi.rlast   = s_rlast;
    assign axi.rid     = '0;
    assign axi.rresp   = '0;

    assign ar_hs      = axi.arvalid && axi.arready;
    assign r_hs       = s_rvalid && axi.rready;
    assign r_busy_now = ar_hs || (s_rbusy && !(r_hs && s_rlast));
    assign r_nbeat    = ar_hs ? 9'd0 : s_rbeat;
    assign r_len      = ar_hs ? axi.arlen : s_rlen;
    assign r_addr     = ar_hs ? axi.araddr[7:0] : s_raddr;
    assign r_baddr    = (r_addr & 8'hfc) + 8'(r_nbeat * 4);
    assign w_baddr    = (s_waddr & 8'hfc) + 8'(s_wbeat * 4);

    always @(posedge clk) begin
        if (!rstn) begin
            if (!s_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
                s_init <= 1'b1;
            end
            go_aw <= 1'b1; go_w <= 1'b1; go_r <= 1'b1;
            s_awgot <= 1'b0; s_bpend <= 1'b0; s_wbeat <= '0; s_waddr <= '0;
            s_rbusy <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rbeat <= '0;
            s_raddr <= '0; s_rlen <= '0; s_rdata <= '0;
        end else begin
            go_aw <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            go_w  <= hold_w ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            go_r  <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.awvalid && axi.awready) begin
                s_awgot <= 1'b1;
                s_waddr <= axi.awaddr[7:0];
                s_wbeat <= '0;
            end
            if (axi.wvalid && axi.wready) begin
                for (int j = 0; j < 4; j++)
                    if (axi.wstrb[j]) mem[w_baddr + 8'(j)] <= axi.wdata[8*j +: 8];
                s_wbeat <= s_wbeat + 9'd1;
                if (axi.wlast) begin
                    s_awgot <= 1'b0;
                    s_bpend <= 1'b1;
                end
            end
            if (axi.bvalid && axi.bready) s_bpend <= 1'b0;
            if (ar_hs) begin
                s_rbusy <= 1'b1;
                s_raddr <= axi.araddr[7:0];
                s_rlen  <= axi.arlen;
                s_rbeat <= '0;
            end
            if (r_hs) begin
                s_rvalid <= 1'b0;
                if (s_rlast) s_rbusy <= 1'b0;
            end
            if ((!s_rvalid || axi.rready) && r_busy_now && (r_nbeat <= {1'b0, r_len}) && go_r) begin
                s_rvalid <= 1'b1;
                s_rdata  <= {mem[r_baddr + 8'd3], mem[r_baddr + 8'd2],
                             mem[r_baddr + 8'd1], mem[r_baddr]};
                s_rlast  <= (r_nbeat == {1'b0, r_len});
                s_rbeat  <= r_nbeat + 9'd1;
            end
        end
    end

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        logic [63:0] data;
        int          acc;
    } rexp_t;
    rexp_t rq[$];
    int    wq[$];

    // monitor: protocol checks and scoreboard pops, sampled on the falling edge
    initial begin
        logic        p_awv, p_awr, p_wv, p_wr, p_wlast, p_arv, p_arr, p_wdone, p_rdone;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        int          mon_wbeat;
        rexp_t       e;
        int          wa;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_wlast = 0; p_arv = 0; p_arr = 0;
        p_wdone = 0; p_rdone = 0; p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        mon_wbeat = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                p_awv = 0; p_wv = 0; p_arv = 0; p_wdone = 0; p_rdone = 0;
                mon_wbeat = 0;
            end else begin
                if (p_awv && !p_awr)
                    chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)
                    chk("w_hold", {axi.wvalid, axi.wlast, axi.wstrb, axi.wdata},
                        {1'b1, p_wlast, p_wstrb, p_wdata});
                if (p_arv && !p_arr)
                    chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
                if (axi.awvalid && axi.awready)
                    chk("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock,
                                      axi.awcache, axi.awprot, axi.awqos, axi.awregion},
                        {4'h0, 8'd1, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0});
                if (axi.arvalid && axi.arready)
                    chk("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock,
                                      axi.arcache, axi.arprot, axi.arqos, axi.arregion},
                        {4'h0, 8'd1, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0});
                if (axi.wvalid && axi.wready) begin
                    chk("wlast_place", axi.wlast, (mon_wbeat == BL - 1));
                    mon_wbeat = axi.wlast ? 0 : mon_wbeat + 1;
                end
                if (p_wdone) chk("wdone_pulse", wdone, 1'b0);
                if (p_rdone) chk("rdone_pulse", rdone, 1'b0);
                if (rdone) begin
                    if (rq.size() == 0) begin
                        chk("rdone_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = rq.pop_front();
                        chk("rdata", rdata, e.data);
                        if (!stall) chk("rdone_latency", 64'(cyc - e.acc), 64'(BL + 2));
                    end
                end
                if (wdone) begin
                    if (wq.size() == 0) begin
                        chk("wdone_unexpected", 1'b1, 1'b0);
                    end else begin
                        wa = wq.pop_front();
                        if (!stall) chk("wdone_latency", 64'(cyc - wa), 64'(BL + 3));
                    end
                end
                p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
                p_wv = axi.wvalid; p_wr = axi.wready; p_wlast = axi.wlast;
                p_wdata = axi.wdata; p_wstrb = axi.wstrb;
                p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
                p_wdone = wdone; p_rdone = rdone;
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic wait_ready(input logic need_w, input logic need_r);
        int n = 0;
        while (!((!need_w || wready === 1'b1) && (!need_r || rready_u === 1'b1)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic drive_w(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        waddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
        wq.push_back(cyc);
    endtask

    task automatic drive_r(input logic [31:0] a, input logic [63:0] exp);
        rexp_t e;
        e.data = exp; e.acc = cyc;
        raddr = a; rvalid_u = 1'b1;
        rq.push_back(e);
    endtask

    task automatic finish_drive();
        @(posedge clk);
        #1;
        wvalid = 1'b0; rvalid_u = 1'b0;
        waddr = '1; wdata = '1; wstrb = '1; raddr = '1;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        wait_ready(1'b1, 1'b0);
        drive_w(a, d, s);
        finish_drive();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] exp);
        wait_ready(1'b0, 1'b1);
        drive_r(a, exp);
        finish_drive();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        // reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {wready, rready_u, wdone, rdone, axi.awvalid, axi.wvalid, axi.wlast,
                              axi.bready, axi.arvalid, axi.rready}, 10'b0);
        chk("reset_rdata", rdata, 64'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {wready, rready_u}, 2'b11);

        // basic round trip
        do_write(32'h10, 64'h0000000000001234, 8'hff);
        wait_idle();
        do_read(32'h10, 64'h0000000000001234);
        wait_idle();

        // back-to-back writes and overlapping reads
        do_write(32'h10, 64'h1234567890abcdef, 8'hff);
        do_write(32'h18, 64'hcdef90ab56781234, 8'hff);
        wait_idle();
        do_read(32'h10, 64'h1234567890abcdef);
        do_read(32'h14, 64'h5678123412345678);
        do_read(32'h18, 64'hcdef90ab56781234);
        do_read(32'h1c, 64'h00000000cdef90ab);
        wait_idle();

        // byte strobes
        do_write(32'h20, 64'hcafecafecafecafe, 8'hff);
        wait_idle();
        do_write(32'h20, 64'hbeefbeefbeefbeef, 8'b01100100);
        wait_idle();
        do_read(32'h20, 64'hcaefbefecaefcafe);
        wait_idle();

        // simultaneous read and write
        do_write(32'h30, 64'hc0ffeeadd1c0ffee, 8'hff);
        wait_idle();
        wait_ready(1'b1, 1'b1);
        drive_w(32'h38, 64'h000000000fab1e55, 8'hff);
        drive_r(32'h30, 64'hc0ffeeadd1c0ffee);
        finish_drive();
        wait_idle();
        do_read(32'h38, 64'h000000000fab1e55);
        wait_idle();

        // request while busy is ignored
        do_write(32'h40, 64'h0000000000001111, 8'hff);
        chk("wready_busy", wready, 1'b0);
        waddr = 32'h48; wdata = 64'h2222; wstrb = 8'hff; wvalid = 1'b1;
        finish_drive();
        wait_idle();
        do_read(32'h48, 64'h0);
        do_read(32'h40, 64'h0000000000001111);
        wait_idle();

        // randomised slave backpressure
        stall = 1'b1;
        do_write(32'h50, 64'h0123456789abcdef, 8'hff);
        do_write(32'h58, 64'hfedcba9876543210, 8'hff);
        wait_idle();
        do_read(32'h50, 64'h0123456789abcdef);
        do_read(32'h58, 64'hfedcba9876543210);
        do_read(32'h54, 64'h7654321001234567);
        wait_idle();
        wait_ready(1'b1, 1'b1);
        drive_w(32'h60, 64'ha5a55a5a3c3cc3c3, 8'hff);
        drive_r(32'h10, 64'h1234567890abcdef);
        finish_drive();
        wait_idle();
        do_read(32'h60, 64'ha5a55a5a3c3cc3c3);
        wait_idle();
        stall = 1'b0;

        // reset in the middle of a write data phase
        hold_w = 1'b1;
        do_write(32'h80, 64'h9999999999999999, 8'hff);
        n = 0;
        while (axi.wvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_w_data", axi.wvalid, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {wready, rready_u, axi.awvalid, axi.wvalid, axi.wlast,
                                 axi.bready, axi.arvalid, axi.rready}, 8'b0);
        wq.delete();
        rq.delete();
        hold_w = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", {wready, rready_u}, 2'b11);
        do_read(32'h10, 64'h1234567890abcdef);
        wait_idle();

        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
